// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM family.
// Mode selectors and the byte-lane merge used by writes and forwarding.
package dp_ram_pkg;

    typedef enum int {
        RDW_OLD = 0,
        RDW_NEW = 1
    } rdw_mode_e;

    typedef enum int {
        PRIO_A = 0,
        PRIO_B = 1
    } wr_prio_e;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BE_WIDTH-1:0]   be
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE_WIDTH; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dp_ram_be_if.sv
// One RAM port: request (select, write, byte enables, address, data) and read return.
// The master drives requests; the RAM side is the slave and returns rdata/rvalid.
interface dp_ram_be_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);

    logic                    cs;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;

    modport master (
        output cs,
        output we,
        output be,
        output addr,
        output wdata,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  cs,
        input  we,
        input  be,
        input  addr,
        input  wdata,
        output rdata,
        output rvalid
    );

endinterface

// File: rtl/dp_ram_rd_pipe.sv
// Read-return pipeline for one port: one register stage, plus an optional output stage.
// rdata only updates on a valid read so it holds the last value between reads.
module dp_ram_rd_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= req_valid;
            if (req_valid) begin
                s1_data <= req_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid <= 1'b0;
                    rdata  <= '0;
                end else begin
                    rvalid <= s1_valid;
                    if (s1_valid) begin
                        rdata <= s1_data;
                    end
                end
            end
        end else begin : g_no_out_reg
            assign rvalid = s1_valid;
            assign rdata  = s1_data;
        end
    endgenerate

endmodule

// File: rtl/dp_ram_be.sv
// True dual-port RAM with byte enables, same-address collision resolution,
// optional cross-port write forwarding and a saturating collision counter.
module dp_ram_be
    import dp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int OUT_REG    = 0,
    parameter int RDW_MODE   = 0,
    parameter int WR_PRIO    = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    dp_ram_be_if.slave   port_a,
    dp_ram_be_if.slave   port_b,
    output logic         coll_flag,
    output logic [15:0]  coll_count
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  a_in_range, b_in_range;
    logic [IDX_W-1:0]      a_idx, b_idx;
    logic                  a_wr, b_wr, a_rd, b_rd;
    logic                  same_addr, collision;
    logic [DATA_WIDTH-1:0] a_old, b_old;
    logic [DATA_WIDTH-1:0] a_word, b_word, dual_word;
    logic [DATA_WIDTH-1:0] a_rd_data, b_rd_data;

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_W-1:0]       be
    );
        return DATA_WIDTH'(be_merge(MAX_DATA_WIDTH'(old_word),
                                    MAX_DATA_WIDTH'(new_word),
                                    MAX_BE_WIDTH'(be)));
    endfunction

    assign a_in_range = ({1'b0, port_a.addr} < (ADDR_WIDTH+1)'(DEPTH));
    assign b_in_range = ({1'b0, port_b.addr} < (ADDR_WIDTH+1)'(DEPTH));
    assign a_idx      = port_a.addr[IDX_W-1:0];
    assign b_idx      = port_b.addr[IDX_W-1:0];

    // A zero byte-enable write or an out-of-range write never touches the array.
    assign a_wr = port_a.cs & port_a.we & (|port_a.be) & a_in_range;
    assign b_wr = port_b.cs & port_b.we & (|port_b.be) & b_in_range;
    assign a_rd = port_a.cs & ~port_a.we;
    assign b_rd = port_b.cs & ~port_b.we;

    assign same_addr = a_in_range & b_in_range & (port_a.addr == port_b.addr);
    assign collision = port_a.cs & port_b.cs & same_addr &
                       ((port_a.we & (|port_a.be)) | (port_b.we & (|port_b.be)));

    // Merged words: the priority port is applied last so its lanes win.
    always_comb begin
        a_old     = a_in_range ? mem[a_idx] : '0;
        b_old     = b_in_range ? mem[b_idx] : '0;
        a_word    = merge(a_old, port_a.wdata, port_a.be);
        b_word    = merge(b_old, port_b.wdata, port_b.be);
        dual_word = a_word;
        if (WR_PRIO == int'(PRIO_B)) begin
            dual_word = merge(a_word, port_b.wdata, port_b.be);
        end else begin
            dual_word = merge(b_word, port_a.wdata, port_a.be);
        end
    end

    // Reads see pre-write data unless forwarding of the other port's write is enabled.
    always_comb begin
        a_rd_data = a_old;
        b_rd_data = b_old;
        if (RDW_MODE == int'(RDW_NEW)) begin
            if (b_wr && same_addr) begin
                a_rd_data = b_word;
            end
            if (a_wr && same_addr) begin
                b_rd_data = a_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_wr && b_wr && same_addr) begin
            mem[a_idx] <= dual_word;
        end else begin
            if (a_wr) begin
                mem[a_idx] <= a_word;
            end
            if (b_wr) begin
                mem[b_idx] <= b_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_flag  <= 1'b0;
            coll_count <= '0;
        end else begin
            coll_flag <= collision;
            if (collision && (coll_count != 16'hFFFF)) begin
                coll_count <= coll_count + 16'd1;
            end
        end
    end

    dp_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_a_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (a_rd),
        .req_data  (a_rd_data),
        .rvalid    (port_a.rvalid),
        .rdata     (port_a.rdata)
    );

    dp_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_b_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (b_rd),
        .req_data  (b_rd_data),
        .rvalid    (port_b.rvalid),
        .rdata     (port_b.rdata)
    );

endmodule

// File: tb/tb_dp_ram_be.sv
// Directed bench for dp_ram_be: dut0 uses defaults; dut1 has DEPTH=12, OUT_REG=1,
// RDW_MODE=1 and WR_PRIO=1 and receives identical stimulus.
module tb_dp_ram_be;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dp_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) a0_if ();
    dp_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) b0_if ();
    dp_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) a1_if ();
    dp_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) b1_if ();

    logic        coll_flag0, coll_flag1;
    logic [15:0] coll_count0, coll_count1;

    dp_ram_be #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16),
        .OUT_REG(0), .RDW_MODE(0), .WR_PRIO(0)
    ) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .port_a     (a0_if),
        .port_b     (b0_if),
        .coll_flag  (coll_flag0),
        .coll_count (coll_count0)
    );

    dp_ram_be #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12),
        .OUT_REG(1), .RDW_MODE(1), .WR_PRIO(1)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .port_a     (a1_if),
        .port_b     (b1_if),
        .coll_flag  (coll_flag1),
        .coll_count (coll_count1)
    );

    int          check_count = 0;
    int          pass_count  = 0;
    int          fail_count  = 0;
    logic [15:0] exp0 [16];
    logic [15:0] exp1 [16];
    int          p0a, p0b, p1a, p1b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit on_b, input logic cs, input logic we,
                                 input logic [1:0] be, input logic [3:0] addr,
                                 input logic [15:0] wdata);
        if (!on_b) begin
            a0_if.cs = cs; a0_if.we = we; a0_if.be = be; a0_if.addr = addr; a0_if.wdata = wdata;
            a1_if.cs = cs; a1_if.we = we; a1_if.be = be; a1_if.addr = addr; a1_if.wdata = wdata;
        end else begin
            b0_if.cs = cs; b0_if.we = we; b0_if.be = be; b0_if.addr = addr; b0_if.wdata = wdata;
            b1_if.cs = cs; b1_if.we = we; b1_if.be = be; b1_if.addr = addr; b1_if.wdata = wdata;
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] fill_word(input int i);
        logic [3:0] n;
        n = 4'(i);
        return {n, 4'hC, ~n, n};
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < 16; i++) begin
            exp0[i] = fill_word(i);
            exp1[i] = (i < 12) ? fill_word(i) : 16'h0000;
        end
        tick();
        tick();

        checkOutput("reset a0 rdata",  a0_if.rdata, 16'h0000);
        checkOutput("reset a0 rvalid", 16'(a0_if.rvalid), 16'h0000);
        checkOutput("reset b0 rvalid", 16'(b0_if.rvalid), 16'h0000);
        checkOutput("reset flag0",     16'(coll_flag0), 16'h0000);
        checkOutput("reset count0",    coll_count0, 16'h0000);
        checkOutput("reset a1 rdata",  a1_if.rdata, 16'h0000);
        checkOutput("reset b1 rvalid", 16'(b1_if.rvalid), 16'h0000);
        checkOutput("reset count1",    coll_count1, 16'h0000);

        rst_n = 1'b1;
        tick();

        $display("[TB] fill array: A even, B odd addresses");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'(2*i),   fill_word(2*i));
            applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, 4'(2*i+1), fill_word(2*i+1));
            tick();
        end
        idle();
        checkOutput("fill no collision", coll_count0, 16'h0000);

        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd2, 16'h0000);
        tick();
        exp0[2] = 16'h0000;
        exp1[2] = 16'h0000;

        $display("[TB] write/read 0x1234 at 3");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd3, 16'h1234);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0000);
        tick();
        idle();
        checkOutput("rd3 a0 rvalid", 16'(a0_if.rvalid), 16'h0001);
        checkOutput("rd3 a0 rdata",  a0_if.rdata, 16'h1234);
        checkOutput("rd3 a1 early rvalid", 16'(a1_if.rvalid), 16'h0000);
        tick();
        checkOutput("rd3 a0 rvalid pulse", 16'(a0_if.rvalid), 16'h0000);
        checkOutput("rd3 a0 rdata hold",   a0_if.rdata, 16'h1234);
        checkOutput("rd3 a1 rvalid", 16'(a1_if.rvalid), 16'h0001);
        checkOutput("rd3 a1 rdata",  a1_if.rdata, 16'h1234);
        exp0[3] = 16'h1234;
        exp1[3] = 16'h1234;

        $display("[TB] byte enables at 5");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd5, 16'hAAAA);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 4'd5, 16'h5555);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 4'd5, 16'hFFFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 4'd5, 16'h0000);
        tick();
        idle();
        checkOutput("be b0 rdata",  b0_if.rdata, 16'hAA55);
        checkOutput("be0 no flag0", 16'(coll_flag0), 16'h0000);
        checkOutput("be0 no flag1", 16'(coll_flag1), 16'h0000);
        tick();
        checkOutput("be b1 rdata",  b1_if.rdata, 16'hAA55);
        exp0[5] = 16'hAA55;
        exp1[5] = 16'hAA55;

        $display("[TB] dual-write collisions");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd7, 16'h1111);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, 4'd7, 16'h2222);
        tick();
        checkOutput("ww7 flag0",  16'(coll_flag0), 16'h0001);
        checkOutput("ww7 count0", coll_count0, 16'h0001);
        checkOutput("ww7 count1", coll_count1, 16'h0001);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd9, 16'h5566);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 4'd9, 16'h7788);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd14, 16'h0E0E);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, 4'd14, 16'hE0E0);
        tick();
        checkOutput("ww14 flag0",  16'(coll_flag0), 16'h0001);
        checkOutput("ww14 oor flag1", 16'(coll_flag1), 16'h0000);
        checkOutput("ww14 count0", coll_count0, 16'h0003);
        checkOutput("ww14 count1", coll_count1, 16'h0002);
        exp0[7] = 16'h1111; exp1[7] = 16'h2222;
        exp0[9] = 16'h5566; exp1[9] = 16'h5588;
        exp0[14] = 16'h0E0E;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 4'd7, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 4'd9, 16'h0000);
        tick();
        checkOutput("ww7 a0 rdata", a0_if.rdata, 16'h1111);
        checkOutput("ww9 b0 rdata", b0_if.rdata, 16'h5566);
        checkOutput("flag0 drops",  16'(coll_flag0), 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 4'd14, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
        tick();
        idle();
        checkOutput("ww14 a0 rdata", a0_if.rdata, 16'h0E0E);
        checkOutput("ww7 a1 rdata",  a1_if.rdata, 16'h2222);
        checkOutput("ww9 b1 rdata",  b1_if.rdata, 16'h5588);
        tick();
        checkOutput("oor a1 rvalid", 16'(a1_if.rvalid), 16'h0001);
        checkOutput("oor a1 rdata",  a1_if.rdata, 16'h0000);

        $display("[TB] cross-port read during write at 2");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd2, 16'hBEEF);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 4'd2, 16'h0000);
        tick();
        idle();
        checkOutput("rdw b0 rvalid", 16'(b0_if.rvalid), 16'h0001);
        checkOutput("rdw b0 old",    b0_if.rdata, 16'h0000);
        checkOutput("rdw count0",    coll_count0, 16'h0004);
        checkOutput("rdw count1",    coll_count1, 16'h0003);
        tick();
        checkOutput("rdw b1 fwd",    b1_if.rdata, 16'hBEEF);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 4'd2, 16'h0000);
        tick();
        idle();
        checkOutput("rdw b0 next", b0_if.rdata, 16'hBEEF);
        tick();
        checkOutput("rdw b1 next", b1_if.rdata, 16'hBEEF);
        exp0[2] = 16'hBEEF;
        exp1[2] = 16'hBEEF;

        $display("[TB] back-to-back sweep on both ports");
        p0a = 0; p0b = 0; p1a = 0; p1b = 0;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 4'(k), 16'h0000);
                applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 4'(15-k), 16'h0000);
            end else begin
                idle();
            end
            tick();
            if (a0_if.rvalid) p0a++;
            if (b0_if.rvalid) p0b++;
            if (a1_if.rvalid) p1a++;
            if (b1_if.rvalid) p1b++;
            if (k < 16) begin
                checkOutput("sweep a0", a0_if.rdata, exp0[k]);
                checkOutput("sweep b0", b0_if.rdata, exp0[15-k]);
            end
            if (k >= 1 && k < 17) begin
                checkOutput("sweep a1", a1_if.rdata, exp1[k-1]);
                checkOutput("sweep b1", b1_if.rdata, exp1[16-k]);
            end
        end
        checkOutput("sweep a0 pulses", 16'(p0a), 16'd16);
        checkOutput("sweep b0 pulses", 16'(p0b), 16'd16);
        checkOutput("sweep a1 pulses", 16'(p1a), 16'd16);
        checkOutput("sweep b1 pulses", 16'(p1b), 16'd16);

        $display("[TB] reset during read");
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0000);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        checkOutput("rst a0 rvalid", 16'(a0_if.rvalid), 16'h0000);
        checkOutput("rst a0 rdata",  a0_if.rdata, 16'h0000);
        checkOutput("rst a1 rdata",  a1_if.rdata, 16'h0000);
        checkOutput("rst count0",    coll_count0, 16'h0000);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("rst a1 dropped", 16'(a1_if.rvalid), 16'h0000);
        end
        rst_n = 1'b1;
        tick();
        checkOutput("post-rst a1 rvalid", 16'(a1_if.rvalid), 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 4'd9, 16'h0000);
        tick();
        idle();
        checkOutput("retain a0", a0_if.rdata, 16'h1234);
        checkOutput("retain b0", b0_if.rdata, 16'h5566);
        tick();
        checkOutput("retain a1", a1_if.rdata, 16'h1234);
        checkOutput("retain b1", b1_if.rdata, 16'h5588);

        $display("[TB] collision counter saturation");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4'd0, 16'h0001);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, 4'd0, 16'h0002);
        for (int k = 0; k < 65540; k++) begin
            tick();
        end
        idle();
        checkOutput("sat count0", coll_count0, 16'hFFFF);
        checkOutput("sat count1", coll_count1, 16'hFFFF);
        checkOutput("sat flag0",  16'(coll_flag0), 16'h0001);
        tick();
        checkOutput("sat hold count0", coll_count0, 16'hFFFF);
        checkOutput("sat flag0 clear", 16'(coll_flag0), 16'h0000);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
